// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS layout and transmit state encoding.
package mmio_uart_pkg;

    localparam int unsigned BAUD_W = 16;

    localparam logic [3:0] OFF_TXDATA  = 4'h0;
    localparam logic [3:0] OFF_STATUS  = 4'h4;
    localparam logic [3:0] OFF_BAUDDIV = 4'h8;

    localparam int unsigned ST_FULL_BIT  = 0;
    localparam int unsigned ST_EMPTY_BIT = 1;
    localparam int unsigned ST_BUSY_BIT  = 2;
    localparam int unsigned ST_OVF_BIT   = 3;
    localparam int unsigned ST_CNT_LSB   = 4;
    localparam int unsigned ST_CNT_W     = 7;

    // STATUS word as returned on the read port
    typedef struct packed {
        logic [20:0]         rsvd;
        logic [ST_CNT_W-1:0] count;
        logic                overflow;
        logic                busy;
        logic                empty;
        logic                full;
    } status_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte-wide synchronous FIFO; a push while full is accepted only when a pop
// happens in the same cycle.
module uart_byte_fifo #(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [7:0]                    din,
    input  logic                          pop,
    output logic [7:0]                    dout,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// UART transmitter on the MIPS data-memory bus: stores to TXDATA are queued
// and sent 8N1 on TxD; STATUS/BAUDDIV are read back combinationally.
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter logic [31:0]       IO_BASE         = 32'hFFFF_0000,
    parameter int unsigned       FIFO_DEPTH      = 8,
    parameter logic [BAUD_W-1:0] DEFAULT_BAUDDIV = 16'd434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] ReadData,
    output logic        io_hit,
    output logic        TxD
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [3:0]        off;
    logic              wr_en, push, status_wr, baud_wr;
    logic              pop;
    logic [7:0]        fifo_dout;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_div_q, baud_div_d;
    logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              txd_q, txd_d;
    logic              ovf_q, ovf_d;
    logic              bit_end;
    status_t           status;
    logic              unused_bits;

    assign unused_bits = ^WriteData[31:16];

    assign off       = Address[3:0];
    assign io_hit    = (Address[31:4] == IO_BASE[31:4]);
    assign wr_en     = MemWrite && io_hit;
    assign push      = wr_en && (off == OFF_TXDATA);
    assign status_wr = wr_en && (off == OFF_STATUS);
    assign baud_wr   = wr_en && (off == OFF_BAUDDIV);

    // >= rather than == so a smaller divisor written mid-bit cannot hang
    assign bit_end   = (baud_cnt_q >= (baud_div_q - BAUD_W'(1)));

    uart_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (WriteData[7:0]),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= TX_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TX_IDLE:  if (!fifo_empty) state_d = TX_START;
            TX_START: if (bit_end) state_d = TX_DATA;
            TX_DATA:  if (bit_end && (bit_cnt_q == 3'd7)) state_d = TX_STOP;
            TX_STOP:  if (bit_end) state_d = fifo_empty ? TX_IDLE : TX_START;
            default:  state_d = TX_IDLE;
        endcase
    end

    // Datapath next values; a pop loads the shifter for the frame just starting
    always_comb begin
        pop        = 1'b0;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        txd_d      = 1'b1;

        if (state_q == TX_IDLE) begin
            baud_cnt_d = '0;
            if (!fifo_empty) begin
                pop       = 1'b1;
                shift_d   = fifo_dout;
                bit_cnt_d = '0;
            end
        end else begin
            baud_cnt_d = bit_end ? '0 : baud_cnt_q + BAUD_W'(1);
            case (state_q)
                TX_START: if (bit_end) bit_cnt_d = '0;
                TX_DATA: begin
                    if (bit_end && (bit_cnt_q != 3'd7)) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end
                TX_STOP: begin
                    if (bit_end && !fifo_empty) begin
                        pop       = 1'b1;
                        shift_d   = fifo_dout;
                        bit_cnt_d = '0;
                    end
                end
                default: ;
            endcase
        end

        case (state_d)
            TX_START: txd_d = 1'b0;
            TX_DATA:  txd_d = shift_d[0];
            default:  txd_d = 1'b1;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (status_wr)                         ovf_d = 1'b0;
        else if (push && fifo_full && !pop)    ovf_d = 1'b1;

        baud_div_d = baud_div_q;
        if (baud_wr)
            baud_div_d = (WriteData[15:0] == 16'd0) ? BAUD_W'(1) : WriteData[15:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            baud_div_q <= DEFAULT_BAUDDIV;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
            ovf_q      <= 1'b0;
        end else begin
            baud_div_q <= baud_div_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
            ovf_q      <= ovf_d;
        end
    end

    assign TxD = txd_q;

    always_comb begin
        status          = '0;
        status.full     = fifo_full;
        status.empty    = fifo_empty;
        status.busy     = (state_q != TX_IDLE);
        status.overflow = ovf_q;
        status.count    = ST_CNT_W'(fifo_count);
    end

    always_comb begin
        ReadData = 32'h0;
        if (MemRead && io_hit) begin
            case (off)
                OFF_STATUS:  ReadData = status;
                OFF_BAUDDIV: ReadData = {16'h0, baud_div_q};
                default:     ReadData = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a serial-line monitor decodes every frame and
// checks it against bytes the stimulus side queued as accepted.
module tb_mmio_uart_tx;

    localparam logic [31:0] IO_BASE = 32'hFFFF_0000;
    localparam int          DEPTH   = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address, WriteData, ReadData;
    logic        MemWrite, MemRead, io_hit, TxD;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q[$];
    int          start_q[$];
    bit          in_frame = 1'b0;
    int          cur_div = 434;
    bit          model_ovf = 1'b0;
    int          last_wr_cyc = 0;

    mmio_uart_tx dut (
        .clk       (clk),
        .reset     (reset),
        .Address   (Address),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .ReadData  (ReadData),
        .io_hit    (io_hit),
        .TxD       (TxD)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] exp_status(input int occ, input bit busy, input bit ovf);
        logic [6:0] c;
        c = 7'(occ);
        return {21'b0, c, ovf, busy, (occ == 0), (occ == DEPTH)};
    endfunction

    // Serial receiver: each frame must be exactly 10*div samples of the ideal waveform
    initial begin
        logic       r, s, expv;
        logic [7:0] eb, rb;
        bit         shape_ok, have_exp;
        int         div, idx, b;
        forever begin
            @(posedge clk);
            r = reset;
            #1 s = TxD;
            if (r) begin
                exp_q.delete();
                in_frame = 1'b0;
                continue;
            end
            if (!in_frame && s === 1'b0) begin
                start_q.push_back(cyc);
                have_exp = (exp_q.size() != 0);
                if (have_exp) eb = exp_q.pop_front();
                else begin
                    eb = 8'h00;
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame: start bit at cycle %0d with nothing queued", cyc);
                end
                in_frame = 1'b1;
                div = cur_div;
                idx = 0;
                shape_ok = 1'b1;
                rb = 8'h00;
            end
            if (in_frame) begin
                b = idx / div;
                expv = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : eb[b-1];
                if (s !== expv) shape_ok = 1'b0;
                if (b >= 1 && b <= 8 && (idx % div) == div / 2) rb[b-1] = s;
                idx++;
                if (idx == 10 * div) begin
                    in_frame = 1'b0;
                    if (have_exp) check("frame{shape_ok,byte}", 32'({shape_ok, rb}), 32'({1'b1, eb}));
                end
            end
        end
    end

    // Called at a negedge; the write is sampled at the following posedge
    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        Address = addr;
        WriteData = data;
        MemWrite = 1'b1;
        last_wr_cyc = cyc + 1;
        if (addr[31:4] == IO_BASE[31:4]) begin
            case (addr[3:0])
                4'h0: if (exp_q.size() < DEPTH) exp_q.push_back(data[7:0]);
                      else model_ovf = 1'b1;
                4'h4: model_ovf = 1'b0;
                4'h8: cur_div = (data[15:0] == 16'd0) ? 1 : int'(data[15:0]);
                default: ;
            endcase
        end
        @(negedge clk);
        MemWrite = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] d, output logic hit);
        Address = addr;
        MemRead = 1'b1;
        #1;
        d = ReadData;
        hit = io_hit;
        MemRead = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic h;
        rd(addr, d, h);
        check(name, d, exp);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || in_frame) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_budget", 32'(n < budget), 32'd1);
        @(negedge clk);
        rd_chk("status_after_drain", IO_BASE + 32'h4, exp_status(0, 1'b0, model_ovf));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        h;
        int          w, s0, s1, occ, gap;
        bit          ok;

        reset = 1'b1;
        Address = '0;
        WriteData = '0;
        MemWrite = 1'b0;
        MemRead = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        rd_chk("reset_status", IO_BASE + 32'h4, 32'h0000_0002);
        rd_chk("reset_bauddiv", IO_BASE + 32'h8, 32'd434);
        rd_chk("txdata_reads_zero", IO_BASE, 32'h0);
        rd(IO_BASE + 32'h4, d, h);
        check("io_hit_in_window", 32'(h), 32'd1);
        check("reset_txd", 32'(TxD), 32'd1);

        // Single frame, latency and busy duration
        wr(IO_BASE + 32'h8, 32'd4);
        start_q.delete();
        wr(IO_BASE, 32'h55);
        w = last_wr_cyc;
        while (cyc < w + 40) @(negedge clk);
        rd_chk("busy_in_last_stop_cycle", IO_BASE + 32'h4, exp_status(0, 1'b1, 1'b0));
        @(negedge clk);
        rd_chk("idle_after_40_cycles", IO_BASE + 32'h4, exp_status(0, 1'b0, 1'b0));
        check("one_frame_55", 32'(start_q.size()), 32'd1);
        if (start_q.size() > 0) check("start_latency", 32'(start_q[0]), 32'(w + 1));
        wait_drain(100);

        // Back-to-back frames without idle gap
        wr(IO_BASE + 32'h8, 32'd2);
        start_q.delete();
        wr(IO_BASE, 32'hA1);
        w = last_wr_cyc;
        wr(IO_BASE, 32'h0F);
        wait_drain(200);
        check("two_frames", 32'(start_q.size()), 32'd2);
        if (start_q.size() == 2) begin
            s0 = start_q[0];
            s1 = start_q[1];
            check("b2b_first_start", 32'(s0), 32'(w + 1));
            check("b2b_no_gap", 32'(s1 - s0), 32'd20);
        end

        // Fill, overflow, overflow clear
        wr(IO_BASE + 32'h8, 32'd1000);
        for (int i = 0; i < 9; i++) wr(IO_BASE, 32'(8'h30 + i));
        rd_chk("status_full", IO_BASE + 32'h4, exp_status(exp_q.size(), 1'b1, model_ovf));
        check("model_fifo_count", 32'(exp_q.size()), 32'd8);
        wr(IO_BASE, 32'h99);
        rd_chk("status_overflow", IO_BASE + 32'h4, exp_status(exp_q.size(), 1'b1, model_ovf));
        check("overflow_expected", 32'(model_ovf), 32'd1);
        wr(IO_BASE + 32'h4, 32'h0);
        rd_chk("status_ovf_cleared", IO_BASE + 32'h4, exp_status(exp_q.size(), 1'b1, model_ovf));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cur_div = 434;
        model_ovf = 1'b0;
        rd_chk("status_after_flush_reset", IO_BASE + 32'h4, 32'h0000_0002);
        rd_chk("bauddiv_after_reset", IO_BASE + 32'h8, 32'd434);

        // BAUDDIV zero, ignored offsets, outside window
        wr(IO_BASE + 32'h8, 32'd0);
        rd_chk("bauddiv_zero_as_one", IO_BASE + 32'h8, 32'd1);
        start_q.delete();
        wr(IO_BASE, 32'hFF);
        w = last_wr_cyc;
        wait_drain(40);
        check("ff_frame_count", 32'(start_q.size()), 32'd1);
        wr(IO_BASE + 32'hC, 32'h5A);
        wr(IO_BASE + 32'h1, 32'h5B);
        wr(32'h1000_0000, 32'h5C);
        repeat (5) @(negedge clk);
        rd_chk("ignored_writes_status", IO_BASE + 32'h4, 32'h0000_0002);
        check("ignored_writes_no_frame", 32'(start_q.size()), 32'd1);
        rd_chk("read_offset_c", IO_BASE + 32'hC, 32'h0);
        rd_chk("read_unaligned", IO_BASE + 32'h5, 32'h0);
        rd(32'h1000_0008, d, h);
        check("non_io_hit", 32'(h), 32'd0);
        check("non_io_readdata", d, 32'h0);
        Address = IO_BASE + 32'h8;
        MemRead = 1'b0;
        #1;
        check("no_memread_readdata", ReadData, 32'h0);

        // Reset during data bit 3 with two bytes queued
        wr(IO_BASE + 32'h8, 32'd4);
        start_q.delete();
        wr(IO_BASE, 32'h3C);
        w = last_wr_cyc;
        wr(IO_BASE, 32'h11);
        wr(IO_BASE, 32'h22);
        while (cyc < w + 1 + 17) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("txd_high_after_reset", 32'(TxD), 32'd1);
        rd_chk("status_after_abort", IO_BASE + 32'h4, 32'h0000_0002);
        reset = 1'b0;
        cur_div = 434;
        model_ovf = 1'b0;
        ok = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (TxD !== 1'b1) ok = 1'b0;
        end
        check("no_frames_after_abort", 32'({ok, 8'(start_q.size())}), 32'({1'b1, 8'd1}));

        // Randomized traffic at several divisors
        for (int round = 0; round < 4; round++) begin
            wr(IO_BASE + 32'h8, 32'($urandom_range(1, 6)));
            for (int k = 0; k < 10; k++) begin
                gap = int'($urandom_range(0, 25));
                repeat (gap) @(negedge clk);
                occ = exp_q.size();
                while (occ >= DEPTH) begin
                    @(negedge clk);
                    occ = exp_q.size();
                end
                wr(IO_BASE, 32'($urandom_range(0, 255)));
            end
            wait_drain(10 * 6 * 12 + 100);
        end

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the data-memory bus of the single-cycle MIPS core. It consumes store traffic: ALU result as address, rt data as write data, plus the control unit's MemWrite and MemRead.
- Stored bytes are queued in a small FIFO and serialized 8N1 on TxD.
- Status is read back through a combinational read port that the top level muxes with DataMemory's ReadData using io_hit.

Parameters:
- IO_BASE, 32'hFFFF_0000, byte base address of the 16-byte register window. Decode uses Address[31:4] only.
- FIFO_DEPTH, 8, entry count; must be a power of two, range 2..64.
- DEFAULT_BAUDDIV, 16'd434, clocks per bit after reset (50 MHz / 115200).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- Address  input  32  byte address from the ALU result.
- WriteData  input  32  store data; only [15:0] are used.
- MemWrite  input  1  store strobe for the current instruction.
- MemRead  input  1  load strobe for the current instruction.
- ReadData  output  32  register read data; combinational.
- io_hit  output  1  combinational; 1 when Address[31:4] == IO_BASE[31:4].
- TxD  output  1  serial line; idle high.

Behaviour:
- Clocking and reset (already decided): one clock, clk; reset is synchronous and active-high, named reset.
- Register map (offset = Address[3:0]):
  - 0x0 TXDATA: write pushes WriteData[7:0]; read returns 0.
  - 0x4 STATUS, read-only bits:
    - [0] full
    - [1] empty
    - [2] busy (state != IDLE)
    - [3] overflow (sticky)
    - [10:4] fifo count
    - others 0
  - 0x4 STATUS write: any write clears overflow.
  - 0x8 BAUDDIV: R/W, [15:0]; written value 0 is stored as 1.
  - 0xC and unaligned offsets: reads return 0, writes are ignored.
- Accesses:
  - Write effective when MemWrite & io_hit.
  - ReadData = register value when MemRead & io_hit, else 32'h0.
- Reset values: TxD=1, state IDLE, FIFO empty (count 0), overflow=0, BAUDDIV=DEFAULT_BAUDDIV, bit counter 0, baud counter 0.
- Reset mid-frame aborts the frame; TxD is high from the cycle after reset is sampled; queued bytes are discarded.
- FIFO:
  - Push is accepted if not full, or if a pop occurs in the same cycle.
  - A push while full with no pop is dropped and sets overflow.
  - A push to an empty FIFO is visible (empty=0) after that edge; it cannot be popped in the same cycle.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - Count saturates at FIFO_DEPTH; it never wraps.
- TX state machine:
  - IDLE → START: when FIFO not empty, pop into shift register; TxD=0 from the next cycle.
  - START → DATA: after one bit period.
  - DATA: 8 bit periods, LSB first.
  - DATA → STOP: TxD=1 for one bit period.
  - At the end of STOP: if FIFO not empty, pop and go directly to START (back-to-back frames, no idle gap); else go to IDLE.
- Bit period:
  - Baud counter counts 0..BAUDDIV-1.
  - A bit ends when count >= BAUDDIV-1; the counter then resets to 0.
  - The >= compare makes a mid-frame BAUDDIV write take effect at the current or next bit boundary without hang.
- Latency: a store at edge N drives TxD low from edge N+1 (IDLE, FIFO empty beforehand). A frame is exactly 10*BAUDDIV cycles.
- Simultaneous STATUS-clear write and an overflowing push cannot occur: there is one access per cycle.

Decomposition:
- Package mmio_uart_pkg:
  - register offset constants (TXDATA, STATUS, BAUDDIV);
  - STATUS bit positions;
  - tx state enum (IDLE, START, DATA, STOP).
- One sub-module, uart_byte_fifo: synchronous FIFO, parameter FIFO_DEPTH.
  - Ports: clk, reset, push, din[7:0], pop, dout[7:0], full, empty, count.
- The top module holds decode, registers, baud counter and FSM.

Test Plan:
- Reset then read STATUS → 32'h0000_0002. Read BAUDDIV → 434. TxD=1.
- BAUDDIV=4; store 0x55 to IO_BASE → TxD low at the next edge, then:
  - bits 1,0,1,0,1,0,1,0, each 4 cycles;
  - stop high 4 cycles;
  - busy=0 after 40 cycles.
- BAUDDIV=2; store 0xA1,0x0F back-to-back → two 20-cycle frames with no idle gap. Second start bit immediately follows the first stop bit.
- BAUDDIV=1000; store 9 bytes with FIFO_DEPTH=8:
  - first byte pops; remaining 8 fill the FIFO; full=1; STATUS count=8.
  - 10th store → dropped, overflow=1.
  - STATUS write → overflow=0.
- BAUDDIV=0 write → reads back 1; frame of 0xFF is 10 cycles. Store to 0xC → no effect. Load from a non-IO address → io_hit=0, ReadData=0.
- Assert reset during DATA bit 3 of 0x3C with 2 bytes queued → TxD=1 next cycle, STATUS=2, no further frames.
